// File: rtl/glyph_pixel_pipe_if.sv
// glyph_pixel_pipe_if: pixel-stream bundle for the text-mode glyph pixel
// generator. Carries the per-pixel request, the glyph ROM address/data pair
// and the coloured pixel result.
//   master : text-buffer read stage / ROM side (drives requests and ROM data)
//   slave  : glyph_pixel_pipe (drives ROM address and pixel result)
interface glyph_pixel_pipe_if #(
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int NUM_GLYPHS = 96,
  parameter int COLOR_W    = 4
);
  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int RW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int AW = (NUM_GLYPHS * GLYPH_H > 1) ? $clog2(NUM_GLYPHS * GLYPH_H) : 1;

  logic                 in_valid;
  logic [7:0]           chr_val;
  logic [2*COLOR_W-1:0] attr;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 cursor_here;
  logic                 frame_start;
  logic [AW-1:0]        rom_addr;
  logic [GLYPH_W-1:0]   rom_data;
  logic                 out_valid;
  logic                 pixel_on;
  logic [COLOR_W-1:0]   pixel_color;

  modport master (
    output in_valid, chr_val, attr, col, row, cursor_here, frame_start, rom_data,
    input  rom_addr, out_valid, pixel_on, pixel_color
  );

  modport slave (
    input  in_valid, chr_val, attr, col, row, cursor_here, frame_start, rom_data,
    output rom_addr, out_valid, pixel_on, pixel_color
  );
endinterface

// File: rtl/glyph_pixel_pipe.sv
// glyph_pixel_pipe: pipelined character-glyph pixel generator.
// Drives a synchronous glyph ROM address combinationally from the pixel
// request, carries the side-band fields alongside the ROM latency, then
// registers a coloured pixel with cursor inversion and out-of-range blanking.
// Latency input -> out_valid is ROM_LAT+1 cycles, one pixel per cycle.
// Optional feature macro: BLINK_EN (frame-counted attribute/cursor blink).
module glyph_pixel_pipe #(
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int FIRST_CHR    = 32,
  parameter int NUM_GLYPHS   = 96,
  parameter int COLOR_W      = 4,
  parameter int ROM_LAT      = 1,
  parameter int CURSOR_TOP   = 14,
  parameter int BLINK_FRAMES = 32
) (
  input logic               clk,
  input logic               rst_n,
  glyph_pixel_pipe_if.slave bus
);
  localparam int CW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int AW = (NUM_GLYPHS * GLYPH_H > 1) ? $clog2(NUM_GLYPHS * GLYPH_H) : 1;

  // All range arithmetic is done at 32 bits so nothing wraps before the
  // final truncation to the ROM address width.
  localparam logic [31:0] FIRST_U = 32'(FIRST_CHR);
  localparam logic [31:0] END_U   = 32'(FIRST_CHR + NUM_GLYPHS);
  localparam logic [31:0] H_U     = 32'(GLYPH_H);
  localparam logic [31:0] W_U     = 32'(GLYPH_W);
  localparam logic [31:0] CTOP_U  = 32'(CURSOR_TOP);

  typedef struct packed {
    logic               valid;
    logic [CW-1:0]      col;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic               oob;
    logic               cur;
    logic               blank;  // blink suppresses the glyph bit
  } sb_t;

  logic [31:0]        chr_ext;
  logic [31:0]        row_ext;
  logic               oob;
  logic               cur_raw;
  logic               blink_phase;
  logic               blink_bit;
  logic [COLOR_W-1:0] bg_in;
  sb_t                sb_in;

  assign chr_ext = 32'(bus.chr_val);
  assign row_ext = 32'(bus.row);
  assign oob     = (chr_ext < FIRST_U) || (chr_ext >= END_U) || (row_ext >= H_U);
  assign cur_raw = bus.cursor_here && (row_ext >= CTOP_U);

  // ROM address: driven every cycle, forced to 0 for characters with no glyph.
  assign bus.rom_addr = oob ? '0 : AW'((chr_ext - FIRST_U) * H_U + row_ext);

`ifdef BLINK_EN
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

  logic [FCW-1:0] frame_cnt;

  // Frame counter: blink_phase flips each time the count wraps.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs blocks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

  assign blink_bit = bus.attr[2*COLOR_W-1];
  assign bg_in     = {1'b0, bus.attr[2*COLOR_W-2:COLOR_W]};
`else
  // Without blink the top attribute bit is an ordinary background bit and
  // frame_start has no function.
  wire unused_frame_start = bus.frame_start;

  assign blink_phase = 1'b0;
  assign blink_bit   = 1'b0;
  assign bg_in       = bus.attr[2*COLOR_W-1:COLOR_W];
`endif

  // Pack the side-band word captured alongside the ROM request.
  // NOTE: every field gets a default first so no path through the block can
  // leave a bit unassigned and infer a latch.
  always_comb begin
    sb_in       = '0;
    sb_in.valid = bus.in_valid;
    sb_in.col   = bus.col;
    sb_in.fg    = bus.attr[COLOR_W-1:0];
    sb_in.bg    = bg_in;
    sb_in.oob   = oob;
    sb_in.cur   = cur_raw && !blink_phase;
    sb_in.blank = blink_bit && blink_phase;
  end

  sb_t [ROM_LAT-1:0] pipe;

  // Side-band delay line matching the ROM read latency.
  // NOTE: the whole side-band word is reset, not just valid: it is a few
  // flops and keeps X out of the held pixel path after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= sb_in;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  sb_t  tail;
  logic glyph_bit;
  logic on_next;

  assign tail = pipe[ROM_LAT-1];

  // Select the glyph bit for this column and apply the cursor inversion.
  always_comb begin
    glyph_bit = 1'b0;
    if (!tail.oob && !tail.blank && (32'(tail.col) < W_U)) begin
      glyph_bit = bus.rom_data[tail.col];
    end
    on_next = glyph_bit ^ tail.cur;
  end

  // Output register: bubbles clear out_valid but hold the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.pixel_on    <= 1'b0;
      bus.pixel_color <= '0;
    end else begin
      bus.out_valid <= tail.valid;
      if (tail.valid) begin
        bus.pixel_on    <= on_next;
        bus.pixel_color <= on_next ? tail.fg : tail.bg;
      end
    end
  end
endmodule
